// File: rtl/blk_ram_pkg.sv
// Shared types and constants for the block-RAM slave: FSM state encoding,
// counter width and the legal read-latency range.
package blk_ram_pkg;

    typedef enum logic [0:0] {
        StInit,
        StIdle
    } state_e;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/blk_ram_rd_pipe.sv
// LAT-deep read-return pipeline. Each data stage loads only behind a valid token,
// so the last stage holds the most recent read result between reads.
module blk_ram_rd_pipe #(
    parameter int unsigned LAT    = 1,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    valid_q;
    logic [DATA_W-1:0] data_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/blk_ram_slv.sv
// Single-port block-RAM slave: clears the array after reset, then serves reads and
// writes with a fixed read latency, flags illegal commands and counts accesses.
module blk_ram_slv
    import blk_ram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datai,
    output logic [DATA_W-1:0] datao,
    output logic              rvalid,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("blk_ram_slv: RD_LAT out of range");
    end
    if (DEPTH > (1 << ADDR_W) || DEPTH == 0) begin : g_bad_depth
        $error("blk_ram_slv: DEPTH does not fit ADDR_W");
    end

    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // The init sweep owns the write port while it runs.
    always_comb begin
        in_range  = ({1'b0, addr} < DepthW);
        wr_ok     = (state_q == StIdle) && write && in_range;
        rd_ok     = (state_q == StIdle) && read && !write && in_range;
        mem_we    = (state_q == StInit) || wr_ok;
        mem_waddr = (state_q == StInit) ? ptr_q : addr;
        mem_wdata = (state_q == StInit) ? INIT_VAL : datai;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Old contents are read, so a same-edge write to the same word is not seen.
    assign mem_rdata = mem[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            ptr_q   <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            err <= 1'b0;
            unique case (state_q)
                StInit: begin
                    err   <= read | write;
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LastAddr) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StIdle: begin
                    err <= (read | write) & (!in_range | (read & write));
                    if (wr_ok && wr_cnt != '1) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    if (rd_ok && rd_cnt != '1) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    blk_ram_rd_pipe #(
        .LAT    (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_ok),
        .in_data   (mem_rdata),
        .out_valid (rvalid),
        .out_data  (datao)
    );

endmodule

// File: tb/tb_blk_ram_slv.sv
// Scoreboard bench: two slaves (DEPTH 256 / RD_LAT 1 and DEPTH 200 / RD_LAT 3) share
// one randomized stimulus stream and are checked against a word-array reference model.
module tb_blk_ram_slv;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] datai = '0;

    logic [15:0] datao  [2];
    logic        rvalid [2];
    logic        busy   [2];
    logic        err    [2];
    logic [15:0] rd_cnt [2];
    logic [15:0] wr_cnt [2];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    logic [15:0] mem_m     [2][256];
    rd_ent_t     rq        [2][$];
    int          busy_left [2];
    int          rd_c      [2];
    int          wr_c      [2];
    logic        exp_err   [2];
    logic [15:0] last_data [2];

    always #5 clk = ~clk;

    blk_ram_slv #(
        .DATA_W (16), .ADDR_W (8), .DEPTH (256), .RD_LAT (1), .INIT_VAL (16'h0000)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .read (read), .write (write), .addr (addr),
        .datai (datai), .datao (datao[0]), .rvalid (rvalid[0]), .busy (busy[0]),
        .err (err[0]), .rd_cnt (rd_cnt[0]), .wr_cnt (wr_cnt[0])
    );

    blk_ram_slv #(
        .DATA_W (16), .ADDR_W (8), .DEPTH (200), .RD_LAT (3), .INIT_VAL (16'h0000)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .read (read), .write (write), .addr (addr),
        .datai (datai), .datao (datao[1]), .rvalid (rvalid[1]), .busy (busy[1]),
        .err (err[1]), .rd_cnt (rd_cnt[1]), .wr_cnt (wr_cnt[1])
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d actual=%0h required=%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) mem_m[k][i] = 16'h0000;
            rq[k].delete();
            busy_left[k] = depth_of(k);
            rd_c[k] = 0;
            wr_c[k] = 0;
            exp_err[k] = 1'b0;
            last_data[k] = 16'h0000;
        end
    endtask

    // Applies the command rules to the inputs sampled at edge number cyc.
    task automatic model_step(input int k);
        logic e;
        e = 1'b0;
        if (busy_left[k] > 0) begin
            e = read | write;
            busy_left[k]--;
        end else if (read || write) begin
            if (int'(addr) >= depth_of(k)) begin
                e = 1'b1;
            end else begin
                if (read && !write) begin
                    rq[k].push_back('{due: cyc + lat_of(k) - 1, data: mem_m[k][addr]});
                    if (rd_c[k] < 65535) rd_c[k]++;
                end
                if (write) begin
                    mem_m[k][addr] = datai;
                    if (wr_c[k] < 65535) wr_c[k]++;
                    e = read;
                end
            end
        end
        exp_err[k] = e;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        read = r;
        write = w;
        addr = a;
        datai = d;
        cycle();
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        read = 1'b0;
        write = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        read = 1'b0;
        write = 1'b0;
        model_reset();
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    // Monitor: compares every DUT output against the model once per cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rd_ent_t ent;
            check("busy", k, int'(busy[k]), (busy_left[k] > 0) ? 1 : 0);
            check("err", k, int'(err[k]), int'(exp_err[k]));
            check("rd_cnt", k, int'(rd_cnt[k]), rd_c[k]);
            check("wr_cnt", k, int'(wr_cnt[k]), wr_c[k]);
            if (rvalid[k]) begin
                if (rq[k].size() == 0) begin
                    check("rvalid_unexpected", k, int'(rvalid[k]), 0);
                end else begin
                    ent = rq[k].pop_front();
                    check("rd_cycle", k, cyc, ent.due);
                    check("rd_data", k, int'(datao[k]), int'(ent.data));
                    last_data[k] = ent.data;
                end
            end else begin
                check("datao_hold", k, int'(datao[k]), int'(last_data[k]));
                if (rq[k].size() > 0 && rq[k][0].due <= cyc) begin
                    check("rvalid_missing", k, int'(rvalid[k]), 1);
                    ent = rq[k].pop_front();
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;

        // Sweep with one stray strobe while busy.
        idle(5);
        drive(1'b0, 1'b1, 8'h05, 16'hDEAD);
        idle(252);

        drive(1'b1, 1'b0, 8'h00, 16'h0);
        drive(1'b1, 1'b0, 8'd127, 16'h0);
        drive(1'b1, 1'b0, 8'd255, 16'h0);
        idle(4);

        drive(1'b0, 1'b1, 8'h10, 16'hA5A5);
        drive(1'b1, 1'b0, 8'h10, 16'h0);
        idle(4);

        drive(1'b1, 1'b1, 8'h20, 16'h1234);
        drive(1'b1, 1'b0, 8'h20, 16'h0);
        idle(4);

        drive(1'b0, 1'b1, 8'hC8, 16'hBEEF);
        drive(1'b1, 1'b0, 8'h00, 16'h0);
        idle(4);

        drive(1'b0, 1'b1, 8'h01, 16'h0011);
        drive(1'b0, 1'b1, 8'h02, 16'h0022);
        drive(1'b0, 1'b1, 8'h03, 16'h0033);
        drive(1'b0, 1'b1, 8'h04, 16'h0044);
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 8'(i), 16'h0);
        idle(4);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            int         p;
            p = $urandom_range(0, 99);
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            drive(p < 40, (p >= 30) && (p < 65), a, 16'($urandom));
        end

        // Reads in flight are flushed by reset.
        drive(1'b1, 1'b0, 8'h01, 16'h0);
        drive(1'b1, 1'b0, 8'h02, 16'h0);
        pulse_reset(2);

        idle(10);
        drive(1'b1, 1'b0, 8'h03, 16'h0);
        idle(89);
        pulse_reset(2);
        idle(258);

        drive(1'b1, 1'b0, 8'h00, 16'h0);
        drive(1'b1, 1'b0, 8'd127, 16'h0);
        drive(1'b1, 1'b0, 8'd255, 16'h0);
        drive(1'b1, 1'b0, 8'h10, 16'h0);
        idle(6);

        for (int k = 0; k < 2; k++) check("queue_drained", k, rq[k].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
